// File: rtl/pic_pkg.sv
// Shared types and phase encodings for the PIC instruction-cycle sequencer.
// Phases are kept as a 2-bit index and decoded to a one-hot Q1..Q4 bus.
package pic_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        SLEEP = 2'd3
    } state_t;

    localparam logic [1:0] PH_Q1 = 2'd0;
    localparam logic [1:0] PH_Q2 = 2'd1;
    localparam logic [1:0] PH_Q3 = 2'd2;
    localparam logic [1:0] PH_Q4 = 2'd3;

    localparam logic [3:0] OH_IDLE = 4'b0000;
    localparam logic [3:0] OH_Q1   = 4'b0001;
    localparam logic [3:0] OH_Q2   = 4'b0010;
    localparam logic [3:0] OH_Q3   = 4'b0100;
    localparam logic [3:0] OH_Q4   = 4'b1000;

    function automatic logic [3:0] ph_onehot(input logic [1:0] ph);
        logic [3:0] oh;
        oh = OH_Q1 << ph;
        return oh;
    endfunction

endpackage

// File: rtl/phase_gen.sv
// Four-phase counter with start/advance/stop controls and a registered
// one-hot phase output; the next one-hot value is exported for strobe timing.
module phase_gen
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_adv,
    input  logic       i_stop,
    output logic [1:0] o_ph,
    output logic [3:0] o_q,
    output logic [3:0] o_q_nxt
);

    logic [1:0] r_ph;
    logic [1:0] w_ph_nxt;
    logic [3:0] r_q;
    logic [3:0] w_q_nxt;

    // Stop idles the bus but keeps the index; a later start always reloads Q1.
    always_comb begin
        w_ph_nxt = r_ph;
        w_q_nxt  = r_q;
        if (i_stop) begin
            w_q_nxt = OH_IDLE;
        end else if (i_start) begin
            w_ph_nxt = PH_Q1;
            w_q_nxt  = OH_Q1;
        end else if (i_adv) begin
            w_ph_nxt = r_ph + 2'd1;
            w_q_nxt  = ph_onehot(w_ph_nxt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph <= PH_Q1;
            r_q  <= OH_IDLE;
        end else begin
            r_ph <= w_ph_nxt;
            r_q  <= w_q_nxt;
        end
    end

    assign o_ph    = r_ph;
    assign o_q     = r_q;
    assign o_q_nxt = w_q_nxt;

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle sequencer: Q1..Q4 phase strobes, fetch/execute overlap
// with flush cycles after skip/branch, core hold and SLEEP/wake.
module instr_cycle_ctrl
    import pic_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             skip_req,
    input  logic             branch_req,
    input  logic             sleep_req,
    input  logic             wake,
    output logic [3:0]       q,
    output logic             pc_inc,
    output logic             rd_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic             ir_load,
    output logic             pc_load,
    output logic             flush,
    output logic             sleeping,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] w_ph;
    logic [3:0] w_q;
    logic [3:0] w_q_nxt;
    logic       w_in_run;
    logic       w_samp;
    logic       w_start;
    logic       w_stop;
    logic       w_adv;

    logic       r_pend;
    logic       r_sleep_pend;
    logic       r_flush;
    logic       r_pc_inc;
    logic       r_rd_en;
    logic       r_exec_en;
    logic       r_wb_en;
    logic       r_ir_load;
    logic       r_pc_load;
    logic       r_sleeping;
    logic [CNT_W-1:0] r_cnt;

    logic       w_flush_nxt;
    logic       w_pend_nxt;
    logic       w_sleep_pend_nxt;
    logic       w_pc_load_nxt;
    logic       w_cnt_inc;

    phase_gen u_phase_gen (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_adv   (w_adv),
        .i_stop  (w_stop),
        .o_ph    (w_ph),
        .o_q     (w_q),
        .o_q_nxt (w_q_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= START;
        else       r_state <= w_state_nxt;
    end

    assign w_in_run = (r_state == RUN);
    assign w_samp   = w_in_run && (w_ph == PH_Q3) && !r_flush;

    // Pending SLEEP wins over hold at the Q4 boundary; hold is re-read on wake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            START: w_state_nxt = RUN;
            RUN: begin
                if (w_ph == PH_Q4) begin
                    if (r_sleep_pend)  w_state_nxt = SLEEP;
                    else if (hold)     w_state_nxt = HOLD;
                end
            end
            HOLD:  if (!hold) w_state_nxt = RUN;
            SLEEP: if (wake)  w_state_nxt = hold ? HOLD : RUN;
            default: w_state_nxt = START;
        endcase
    end

    // A new instruction cycle begins when entering RUN or wrapping out of Q4.
    assign w_start = (w_state_nxt == RUN) && (!w_in_run || (w_ph == PH_Q4));
    assign w_stop  = (w_state_nxt != RUN);
    assign w_adv   = !w_start && !w_stop;

    always_comb begin
        w_flush_nxt      = r_flush;
        w_pend_nxt       = r_pend;
        w_sleep_pend_nxt = r_sleep_pend;
        w_pc_load_nxt    = 1'b0;
        if (w_stop) begin
            w_flush_nxt = 1'b0;
        end else if (w_start) begin
            w_flush_nxt = (r_state == START) || ((r_state != SLEEP) && r_pend);
            w_pend_nxt  = 1'b0;
        end
        if (w_samp) begin
            if (branch_req) begin
                w_pc_load_nxt = 1'b1;
                w_pend_nxt    = 1'b1;
            end else if (skip_req) begin
                w_pend_nxt    = 1'b1;
            end else if (sleep_req) begin
                w_sleep_pend_nxt = 1'b1;
            end
        end
        if (w_state_nxt == SLEEP) begin
            w_sleep_pend_nxt = 1'b0;
            w_pend_nxt       = 1'b0;
        end
    end

    assign w_cnt_inc = w_adv && w_q_nxt[3] && !w_flush_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend       <= 1'b0;
            r_sleep_pend <= 1'b0;
            r_flush      <= 1'b0;
            r_pc_inc     <= 1'b0;
            r_rd_en      <= 1'b0;
            r_exec_en    <= 1'b0;
            r_wb_en      <= 1'b0;
            r_ir_load    <= 1'b0;
            r_pc_load    <= 1'b0;
            r_sleeping   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_pend       <= w_pend_nxt;
            r_sleep_pend <= w_sleep_pend_nxt;
            r_flush      <= w_flush_nxt;
            r_pc_inc     <= w_q_nxt[0];
            r_rd_en      <= w_q_nxt[1];
            r_exec_en    <= w_q_nxt[2] && !w_flush_nxt;
            r_wb_en      <= w_q_nxt[3] && !w_flush_nxt;
            r_ir_load    <= w_q_nxt[3];
            r_pc_load    <= w_pc_load_nxt;
            r_sleeping   <= (w_state_nxt == SLEEP);
            if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign q         = w_q;
    assign pc_inc    = r_pc_inc;
    assign rd_en     = r_rd_en;
    assign exec_en   = r_exec_en;
    assign wb_en     = r_wb_en;
    assign ir_load   = r_ir_load;
    assign pc_load   = r_pc_load;
    assign flush     = r_flush;
    assign sleeping  = r_sleeping;
    assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Bench for instr_cycle_ctrl: per-edge vector table with a queue of expected
// output words, plus hand sequences for async reset and counter wrap.
module tb_instr_cycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hold = 1'b0;
    logic          skip_req = 1'b0;
    logic          branch_req = 1'b0;
    logic          sleep_req = 1'b0;
    logic          wake = 1'b0;
    logic [3:0]    q;
    logic          pc_inc, rd_en, exec_en, wb_en, ir_load, pc_load, flush, sleeping;
    logic [CW-1:0] cycle_cnt;

    instr_cycle_ctrl #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .skip_req   (skip_req),
        .branch_req (branch_req),
        .sleep_req  (sleep_req),
        .wake       (wake),
        .q          (q),
        .pc_inc     (pc_inc),
        .rd_en      (rd_en),
        .exec_en    (exec_en),
        .wb_en      (wb_en),
        .ir_load    (ir_load),
        .pc_load    (pc_load),
        .flush      (flush),
        .sleeping   (sleeping),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          h, s, b, sl, w;
        logic [3:0]    q;
        logic          fl, pcl, slp;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb[$];
    int          total = 0;
    int          bad = 0;

    wire [15:0] act = {q, pc_inc, rd_en, exec_en, wb_en, ir_load, pc_load, flush, sleeping, cycle_cnt};

    // Strobes follow from the expected phase and flush flag.
    function automatic logic [15:0] pack_exp(input vec_t v);
        return {v.q, v.q[0], v.q[1], v.q[2] & ~v.fl, v.q[3] & ~v.fl, v.q[3], v.pcl, v.fl, v.slp, v.cnt};
    endfunction

    task automatic add(input logic h, s, b, sl, w, input logic [3:0] eq,
                       input logic efl, epl, esl, input int ecnt);
        vec_t v;
        v.h = h; v.s = s; v.b = b; v.sl = sl; v.w = w;
        v.q = eq; v.fl = efl; v.pcl = epl; v.slp = esl; v.cnt = ecnt[CW-1:0];
        tbl.push_back(v);
    endtask

    // One full instruction cycle; requests ride on the edge that ends Q3.
    task automatic add_cyc(input logic fl, input int cnt, input logic s, b, sl, input logic pcl);
        add(0, 0, 0, 0, 0, 4'b0001, fl, 0, 0, cnt);
        add(0, 0, 0, 0, 0, 4'b0010, fl, 0, 0, cnt);
        add(0, 0, 0, 0, 0, 4'b0100, fl, 0, 0, cnt);
        add(0, s, b, sl, 0, 4'b1000, fl, pcl, 0, fl ? cnt : cnt + 1);
    endtask

    task automatic check(input string name, input int idx);
        logic [15:0] e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s[%0d]: scoreboard empty", name, idx);
            return;
        end
        e = sb.pop_front();
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s[%0d]: got %b required %b", name, idx, act, e);
        end
    endtask

    task automatic step(input vec_t v, input string name, input int idx);
        hold = v.h; skip_req = v.s; branch_req = v.b; sleep_req = v.sl; wake = v.w;
        sb.push_back(pack_exp(v));
        @(posedge clk);
        #1;
        check(name, idx);
    endtask

    initial begin
        vec_t v;
        int   n;

        add_cyc(1, 0, 0, 0, 0, 0);              // startup fetch-only cycle
        add_cyc(0, 0, 0, 0, 0, 0);
        add_cyc(0, 1, 0, 0, 0, 0);
        add_cyc(0, 2, 0, 0, 0, 0);              // cnt=3 after four cycles
        add_cyc(0, 3, 1, 0, 0, 0);              // skip
        add_cyc(1, 4, 1, 1, 1, 0);              // flush; requests ignored
        add_cyc(0, 4, 1, 1, 0, 1);              // branch+skip: one pc_load
        add_cyc(1, 5, 0, 0, 0, 0);
        add_cyc(0, 5, 1, 0, 0, 0);              // skip, then hold
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 6);
        add_cyc(1, 6, 0, 0, 0, 0);              // pending flush survives hold
        add_cyc(0, 6, 0, 0, 1, 0);              // sleep request
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 7);
        add(1, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 7); // wake with hold -> HOLD
        add(0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 7);
        add(0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 7); // wake in RUN: no effect
        add(0, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 7);
        add(0, 0, 0, 1, 0, 4'b1000, 0, 0, 0, 8);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 8);
        add(0, 0, 0, 0, 1, 4'b0001, 0, 0, 0, 8); // wake straight to Q1
        add(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 8);
        add(0, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 8);
        add(0, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 9);
        add(0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 9);
        add(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 9);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(16'h0000);
        check("reset", 0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], "vec", i);

        // reset asserted mid-Q2 clears outputs without waiting for an edge
        #3 reset = 1'b1;
        #1;
        sb.push_back(16'h0000);
        check("async_rst", 0);
        @(posedge clk);
        #1;
        sb.push_back(16'h0000);
        check("rst_hold", 0);
        reset = 1'b0;

        // startup flush repeats, then 17 executed cycles wrap the 4-bit count
        for (int c = 0; c < 18; c++) begin
            for (int p = 0; p < 4; p++) begin
                v     = '0;
                v.q   = 4'b0001 << p;
                v.fl  = (c == 0);
                n     = (c == 0) ? 0 : ((p == 3) ? c : c - 1);
                v.cnt = n[CW-1:0];
                step(v, "wrap", c * 4 + p);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
